// File: rtl/mem_port_sched.sv
// mem_port_sched: shares one memory port between IF and MEM, data access first, with a global pipeline stall.
module mem_port_sched #(
  parameter int ADDR_W = 32,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       ALUResult,
  input  logic [31:0]       storeVal,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       instr,
  output logic [31:0]       load_data,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cycles
);
  typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;
  state_t state;
  logic data_done, fetch_done, data_pend, fetch_pend, done;
  assign data_pend = (MemRead | MemWrite) & !data_done;
  assign fetch_pend = if_req & !fetch_done;
  assign stall = !reset & (data_pend | fetch_pend);
  assign done = mem_req & mem_ack;
  // done flags only survive while the pipeline is frozen on the same requests
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      data_done <= 1'b0;
      fetch_done <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      instr <= '0;
      load_data <= '0;
      stall_cycles <= '0;
    end else begin
      if (stall) stall_cycles <= stall_cycles + CNT_W'(1);
      data_done <= stall & (data_done | (done & state == DATA));
      fetch_done <= stall & (fetch_done | (done & state == FETCH));
      case (state)
        IDLE:
          if (data_pend) begin
            state <= DATA;
            mem_req <= 1'b1;
            mem_we <= MemWrite;
            mem_addr <= ALUResult[ADDR_W-1:0];
            mem_wdata <= storeVal;
          end else if (fetch_pend) begin
            state <= FETCH;
            mem_req <= 1'b1;
            mem_we <= 1'b0;
            mem_addr <= if_addr;
          end
        DATA:
          if (done) begin
            if (!mem_we) load_data <= mem_rdata;
            if (fetch_pend) begin
              state <= FETCH;
              mem_we <= 1'b0;
              mem_addr <= if_addr;
            end else begin
              state <= IDLE;
              mem_req <= 1'b0;
            end
          end
        FETCH:
          if (done) begin
            instr <= mem_rdata;
            state <= IDLE;
            mem_req <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/mem_port_sched.md
# mem_port_sched

Single-port memory scheduler for the 5-stage MIPS pipeline. Shares one memory port between instruction fetch (IF) and the MEM-stage load/store carried in the EX/MEM register. Serialises the two requests (data first), buffers the returned words, and drives one global `stall` that freezes every pipeline register and the PC until both accesses of the current cycle are complete.

## Interface
- `ADDR_W`, default 32: memory address width.
- `CNT_W`, default 32: width of the stall performance counter.
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `if_req`, in, 1: IF stage wants an instruction word this cycle.
- `if_addr`, in, ADDR_W: PC. Stable while `stall`=1.
- `MemRead`, in, 1: EX/MEM control, load in MEM stage.
- `MemWrite`, in, 1: EX/MEM control, store in MEM stage.
- `ALUResult`, in, 32: data address from EX/MEM. Low ADDR_W bits used.
- `storeVal`, in, 32: store data from EX/MEM.
- `mem_req`, out, 1: registered. Memory transaction valid.
- `mem_we`, out, 1: registered. 1 = write.
- `mem_addr`, out, ADDR_W: registered.
- `mem_wdata`, out, 32: registered.
- `mem_rdata`, in, 32: read data. Valid with `mem_ack`.
- `mem_ack`, in, 1: memory completes the current transaction this cycle.
- `instr`, out, 32: registered fetched word.
- `load_data`, out, 32: registered loaded word.
- `stall`, out, 1: combinational. 1 = pipeline registers and PC hold.
- `stall_cycles`, out, CNT_W: count of cycles with `stall`=1.

## Operation
- `data_need` = `MemRead` | `MemWrite`. If both are 1, the access is treated as a write.
- States:
  - IDLE: no transaction outstanding.
  - DATA: data transaction outstanding.
  - FETCH: fetch transaction outstanding.
- Done flags `data_done` and `fetch_done`. Each is set on completion of its transaction. Both clear on any cycle where `stall`=0, because the pipeline advances and the next cycle's requests are new.
- `stall` = (`data_need` & !`data_done`) | (`if_req` & !`fetch_done`). Forced to 0 while `reset`=1.
- Issue, from IDLE:
  - If `data_need` & !`data_done`: go to DATA and load mem_* with `ALUResult`/`storeVal`/we.
  - Else if `if_req` & !`fetch_done`: go to FETCH and load mem_* with `if_addr`, we=0.
  - Else stay in IDLE with `mem_req`=0.
- Completion is a cycle with `mem_req` & `mem_ack`:
  - Sets the matching done flag.
  - Reads capture `mem_rdata` into `load_data` (DATA state) or `instr` (FETCH state).
  - A write captures nothing.
  - Back-to-back: on the completion edge of DATA, if `if_req` & !`fetch_done`, go straight to FETCH with `mem_req` held at 1 and the new address. Otherwise go to IDLE and drop `mem_req`.
- mem_* outputs are held constant while `mem_req`=1 and no ack has arrived. The memory may insert any number of wait states.
- `mem_ack` while `mem_req`=0 is ignored.
- `instr` and `load_data` hold their value until the next read of the same kind completes.
- `stall_cycles` increments every cycle `stall`=1 and wraps modulo 2^CNT_W.
- Reset mid-transaction:
  - State returns to IDLE and `mem_req` drops at the next edge.
  - Flags clear.
  - An ack arriving after reset is ignored.

## Timing
- Reset values:
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `instr`=0, `load_data`=0, `stall_cycles`=0.
  - State IDLE, flags 0.
- Decision cycle t (IDLE) puts `mem_req`=1 in t+1. The earliest ack is in t+1.
- Fetch only, zero wait:
  - t: `stall`=1, decide.
  - t+1: ack.
  - t+2: `stall`=0, pipeline advances at the end of t+2.
- Load + fetch, zero wait:
  - Data ack in t+1, fetch ack in t+2.
  - `stall`=0 in t+3.
- W wait states per transaction add W cycles each.
- Neither request present: `stall`=0 and the pipeline advances every cycle.

## Test plan
- Reset with `if_req`=1: `mem_req`=0 and `stall`=0 during reset. After release, `mem_req` is 1 one cycle later with `mem_addr`=`if_addr`.
- Fetch, if_addr=0x40, zero wait, rdata=0x8C220004:
  - `stall`=1,1,0 over t..t+2.
  - `instr`=0x8C220004 from t+2.
  - `stall_cycles`=2.
- Load + fetch, ALUResult=0x100, rdata 0xDEADBEEF then 0x00000020:
  - Data transaction first (we=0, addr=0x100), then fetch back-to-back with `mem_req` never low.
  - `load_data`=0xDEADBEEF; `stall` low in t+3.
- Store with 3 wait states, storeVal=0x12345678:
  - mem_* stable for 4 cycles with we=1, wdata=0x12345678.
  - `load_data` unchanged.
- Reset asserted during FETCH wait: `mem_req`=0 the next cycle. A late ack does not change `instr` or the flags.
- No requests for 10 cycles: `stall`=0 throughout and `stall_cycles` unchanged.
